// File: rtl/am_stream_inserter.sv
// Alignment-marker inserter: emits NUM_FLOWS AM blocks MSB-first, then PAYLOAD_BEATS pass-through beats.
// Optional macro AM_STATUS_EN overwrites the top 3 bits of each captured flow block with status.
module am_stream_inserter #(
  parameter int NUM_FLOWS     = 2,
  parameter int AM_BITS       = 1028,
  parameter int OUT_W         = 4,
  parameter int PAYLOAD_BEATS = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_FLOWS*AM_BITS-1:0] am_block,
  input  logic [2:0]                   status,
  input  logic [OUT_W-1:0]             s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [OUT_W-1:0]             m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_is_am,
  output logic                         am_sof,
  output logic [15:0]                  am_count
);

  localparam int BEATS  = AM_BITS / OUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FLOW_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
  localparam int PCNT_W = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [FLOW_W-1:0] LAST_FLOW = FLOW_W'(NUM_FLOWS - 1);
  localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(PAYLOAD_BEATS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_AM      = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [FLOW_W-1:0] flow_q, flow_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [15:0]       count_q, count_d;

  // Shadow is stored per flow with beat 0 (the MSB chunk) at index 0.
  logic [NUM_FLOWS-1:0][BEATS-1:0][OUT_W-1:0] shadow_q, shadow_d, capture;
  logic [NUM_FLOWS*AM_BITS-1:0]               cap_flat;

  always_comb begin
    cap_flat = am_block;
`ifdef AM_STATUS_EN
    for (int f = 0; f < NUM_FLOWS; f++) begin
      cap_flat[f*AM_BITS + AM_BITS - 1 -: 3] = status;
    end
`endif
    for (int f = 0; f < NUM_FLOWS; f++) begin
      for (int b = 0; b < BEATS; b++) begin
        capture[f][b] = cap_flat[f*AM_BITS + AM_BITS - 1 - b*OUT_W -: OUT_W];
      end
    end
  end

`ifndef AM_STATUS_EN
  logic unused_status;
  assign unused_status = ^status;
`endif

  // NOTE: every variable gets a default at the top of a combinational block so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    flow_d   = flow_q;
    beat_d   = beat_q;
    pcnt_d   = pcnt_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          shadow_d = capture;
          flow_d   = '0;
          beat_d   = '0;
          state_d  = ST_AM;
        end
      end
      ST_AM: begin
        if (m_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (flow_q == LAST_FLOW) begin
              flow_d  = '0;
              count_d = count_q + 16'd1;
              pcnt_d  = '0;
              state_d = ST_PAYLOAD;
            end else begin
              flow_d = flow_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (s_valid && m_ready) begin
          if (pcnt_q == LAST_PCNT) begin
            pcnt_d = '0;
            // en is only looked at here and in IDLE, so a group always runs to completion.
            if (en) begin
              shadow_d = capture;
              flow_d   = '0;
              beat_d   = '0;
              state_d  = ST_AM;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      flow_q   <= '0;
      beat_q   <= '0;
      pcnt_q   <= '0;
      count_q  <= '0;
      // NOTE: the shadow is reset deliberately so a restart never replays stale marker contents.
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      flow_q   <= flow_d;
      beat_q   <= beat_d;
      pcnt_q   <= pcnt_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    s_ready = 1'b0;
    m_is_am = 1'b0;
    am_sof  = 1'b0;
    case (state_q)
      ST_AM: begin
        m_data  = shadow_q[flow_q][beat_q];
        m_valid = 1'b1;
        m_is_am = 1'b1;
        am_sof  = (beat_q == '0);
      end
      ST_PAYLOAD: begin
        m_data  = s_data;
        m_valid = s_valid;
        s_ready = m_ready;
      end
      default: ;
    endcase
  end

  assign am_count = count_q;

endmodule

// File: tb/tb_am_stream_inserter.sv
// Directed bench for am_stream_inserter with NUM_FLOWS=2, AM_BITS=16, OUT_W=4, PAYLOAD_BEATS=3.
// Expected nibbles follow the AM_STATUS_EN setting of the build.
module tb_am_stream_inserter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] am_block;
  logic [2:0]  status;
  logic [3:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_is_am;
  logic        am_sof;
  logic [15:0] am_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_a [8];  // group for am_block 32'hABCD_1234
  logic [3:0] exp_b [2];  // first two beats for am_block 32'h5678_9EF0

  am_stream_inserter #(
    .NUM_FLOWS(2), .AM_BITS(16), .OUT_W(4), .PAYLOAD_BEATS(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .am_block(am_block), .status(status),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_is_am(m_is_am), .am_sof(am_sof), .am_count(am_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; am_block = '0; status = 3'b111;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    tick(); tick();
    settle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    total++; if (m_is_am !== 1'b0) begin bad++; $display("FAIL reset_m_is_am got=%b exp=0", m_is_am); end
    total++; if (am_sof !== 1'b0) begin bad++; $display("FAIL reset_am_sof got=%b exp=0", am_sof); end
    total++; if (m_data !== 4'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    total++; if (am_count !== 16'h0) begin bad++; $display("FAIL reset_am_count got=%h exp=0", am_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_am_group();
    am_block = 32'hABCD_1234; en = 1'b1; m_ready = 1'b1;
    settle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL latency_idle_valid got=%b exp=0", m_valid); end
    tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL am_valid[%0d] got=%b exp=1", i, m_valid); end
      total++; if (m_is_am !== 1'b1) begin bad++; $display("FAIL am_is_am[%0d] got=%b exp=1", i, m_is_am); end
      total++; if (m_data !== exp_a[i]) begin bad++; $display("FAIL am_data[%0d] got=%h exp=%h", i, m_data, exp_a[i]); end
      total++; if (am_sof !== (i % 4 == 0)) begin bad++; $display("FAIL am_sof[%0d] got=%b exp=%b", i, am_sof, (i % 4 == 0)); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL am_s_ready[%0d] got=%b exp=0", i, s_ready); end
      total++; if (am_count !== 16'd0) begin bad++; $display("FAIL am_count_mid[%0d] got=%h exp=0", i, am_count); end
      tick();
    end
    settle();
    total++; if (am_count !== 16'd1) begin bad++; $display("FAIL am_count_done got=%h exp=1", am_count); end
    total++; if (m_is_am !== 1'b0) begin bad++; $display("FAIL payload_is_am got=%b exp=0", m_is_am); end
  endtask

  task automatic test_payload();
    logic       sv [6];
    logic [3:0] sd [6];
    sv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sd = '{4'h5, 4'h5, 4'h6, 4'h6, 4'h7, 4'h7};
    for (int i = 0; i < 6; i++) begin
      s_valid = sv[i]; s_data = sd[i];
      settle();
      total++; if (m_valid !== sv[i]) begin bad++; $display("FAIL pay_valid[%0d] got=%b exp=%b", i, m_valid, sv[i]); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pay_s_ready[%0d] got=%b exp=1", i, s_ready); end
      total++; if (m_is_am !== 1'b0) begin bad++; $display("FAIL pay_is_am[%0d] got=%b exp=0", i, m_is_am); end
      if (sv[i]) begin
        total++; if (m_data !== sd[i]) begin bad++; $display("FAIL pay_data[%0d] got=%h exp=%h", i, m_data, sd[i]); end
      end
      tick();
    end
    s_valid = 1'b1; s_data = 4'h8;
    settle();
    total++; if (m_is_am !== 1'b1) begin bad++; $display("FAIL next_group_is_am got=%b exp=1", m_is_am); end
    total++; if (m_data !== exp_a[0]) begin bad++; $display("FAIL next_group_data got=%h exp=%h", m_data, exp_a[0]); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL next_group_s_ready got=%b exp=0", s_ready); end
    total++; if (am_sof !== 1'b1) begin bad++; $display("FAIL next_group_sof got=%b exp=1", am_sof); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick();
    settle();
    total++; if (m_data !== exp_a[5]) begin bad++; $display("FAIL pre_rst_data got=%h exp=%h", m_data, exp_a[5]); end
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", m_valid); end
    total++; if (am_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%h exp=0", am_count); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_s_ready got=%b exp=0", s_ready); end
    tick();
    settle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL idle_hold_valid got=%b exp=0", m_valid); end
    en = 1'b1;
    tick();
    settle();
    total++; if (m_data !== exp_a[0]) begin bad++; $display("FAIL restart_data got=%h exp=%h", m_data, exp_a[0]); end
    total++; if (am_sof !== 1'b1) begin bad++; $display("FAIL restart_sof got=%b exp=1", am_sof); end
  endtask

  task automatic test_stall();
    tick(); tick();
    settle();
    total++; if (m_data !== 4'h3) begin bad++; $display("FAIL stall_pre got=%h exp=3", m_data); end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      total++; if (m_data !== 4'h3) begin bad++; $display("FAIL stall_data[%0d] got=%h exp=3", i, m_data); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, m_valid); end
    end
    m_ready = 1'b1;
    tick();
    settle();
    total++; if (m_data !== 4'h4) begin bad++; $display("FAIL stall_release got=%h exp=4", m_data); end
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 5; i++) tick();
    settle();
    total++; if (am_count !== 16'd1) begin bad++; $display("FAIL drop_count got=%h exp=1", am_count); end
    total++; if (m_is_am !== 1'b0) begin bad++; $display("FAIL drop_payload got=%b exp=0", m_is_am); end
    s_valid = 1'b1; s_data = 4'h9;
    settle();
    total++; if (m_data !== 4'h9) begin bad++; $display("FAIL drop_pass got=%h exp=9", m_data); end
    tick();
    en = 1'b0; m_ready = 1'b0;
    settle();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL backpressure_s_ready got=%b exp=0", s_ready); end
    tick();
    m_ready = 1'b1;
    tick();
    settle();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL drop_still_payload got=%b exp=1", s_ready); end
    tick();
    settle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drop_idle_valid got=%b exp=0", m_valid); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL drop_idle_s_ready got=%b exp=0", s_ready); end
    total++; if (am_count !== 16'd1) begin bad++; $display("FAIL drop_idle_count got=%h exp=1", am_count); end
    tick();
    settle();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drop_idle_hold got=%b exp=0", m_valid); end
  endtask

  task automatic test_shadow();
    am_block = 32'hABCD_1234; en = 1'b1; s_valid = 1'b0;
    tick();
    am_block = 32'h5678_9EF0;
    for (int i = 0; i < 8; i++) begin
      settle();
      total++; if (m_data !== exp_a[i]) begin bad++; $display("FAIL shadow_data[%0d] got=%h exp=%h", i, m_data, exp_a[i]); end
      tick();
    end
    settle();
    total++; if (am_count !== 16'd2) begin bad++; $display("FAIL shadow_count got=%h exp=2", am_count); end
    s_valid = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 2; i++) begin
      settle();
      total++; if (m_data !== exp_b[i]) begin bad++; $display("FAIL new_block_data[%0d] got=%h exp=%h", i, m_data, exp_b[i]); end
      total++; if (m_is_am !== 1'b1) begin bad++; $display("FAIL new_block_is_am[%0d] got=%b exp=1", i, m_is_am); end
      tick();
    end
  endtask

  initial begin
`ifdef AM_STATUS_EN
    exp_a = '{4'hF, 4'h2, 4'h3, 4'h4, 4'hE, 4'hB, 4'hC, 4'hD};
    exp_b = '{4'hF, 4'hE};
`else
    exp_a = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    exp_b = '{4'h9, 4'hE};
`endif
    test_reset();
    test_am_group();
    test_payload();
    test_reset_mid();
    test_stall();
    test_en_drop();
    test_shadow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am_stream_inserter.md
AM_STREAM_INSERTER -- requirements
Module: am_stream_inserter

Interface
REQ-001 SHALL have parameter NUM_FLOWS, default 2, number of AM flow blocks emitted per AM group (1..4).
REQ-002 SHALL have parameter AM_BITS, default 1028, bits per flow AM block.
REQ-003 SHALL have parameter OUT_W, default 4, output beat width; AM_BITS % OUT_W == 0 required.
REQ-004 SHALL have parameter PAYLOAD_BEATS, default 4096, payload transfers between AM groups (>= 1).
REQ-005 SHALL have one clock and a synchronous, active-high reset; all other ports follow.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 en  in  1  start / continue request, sampled at group boundaries only.
REQ-009 am_block  in  NUM_FLOWS*AM_BITS  AM contents; flow f = am_block[f*AM_BITS +: AM_BITS].
REQ-010 status  in  3  AM status field (used only with AM_STATUS_EN).
REQ-011 s_data / s_valid / s_ready  in / in / out  OUT_W / 1 / 1  payload input stream.
REQ-012 m_data / m_valid / m_ready  out / out / in  OUT_W / 1 / 1  output stream.
REQ-013 m_is_am  out  1  current m_data beat is AM content.
REQ-014 am_sof  out  1  first beat of a flow block.
REQ-015 am_count  out  16  completed AM groups, wraps 0xFFFF -> 0x0000.

Function
REQ-016 SHALL use states IDLE, AM, PAYLOAD.
REQ-017 IDLE: m_valid=0, s_ready=0; en=1 -> capture am_block (and status) into shadow register, enter AM with flow=0, beat=0.
REQ-018 Latency: en high at edge N -> first AM beat valid after edge N+1 (registered).
REQ-019 AM: m_valid=1, m_is_am=1, m_data = shadow flow[flow] bits [AM_BITS-1-beat*OUT_W -: OUT_W] (MSB first).
REQ-020 AM advance only on m_valid && m_ready; m_data, flow, beat held stable otherwise.
REQ-021 Beat wraps at AM_BITS/OUT_W-1 -> flow+1; after last beat of flow NUM_FLOWS-1: am_count+1, payload counter=0, enter PAYLOAD.
REQ-022 am_sof=1 exactly when in AM with beat==0.
REQ-023 PAYLOAD: combinational pass-through, m_data=s_data, m_valid=s_valid, s_ready=m_ready, m_is_am=0, am_sof=0.
REQ-024 PAYLOAD counts s_valid && m_ready transfers; on transfer PAYLOAD_BEATS: en=1 -> capture new am_block, enter AM; en=0 -> IDLE.
REQ-025 s_ready SHALL be 0 in IDLE and AM.
REQ-026 en deassert during AM or mid-PAYLOAD SHALL NOT truncate; current group and its payload complete first.
REQ-027 Shadow register SHALL NOT change during AM; am_block changes mid-group take effect next group.

Reset
REQ-028 rst=1 at an edge -> state IDLE, m_valid=0, s_ready=0, m_is_am=0, am_sof=0, m_data=0, am_count=0, flow=0, beat=0, payload counter=0, shadow=0.
REQ-029 Reset mid-AM or mid-PAYLOAD SHALL abandon the group; next start begins at flow 0, beat 0.

Configuration
REQ-030 Macro AM_STATUS_EN defined: at capture, bits [AM_BITS-1:AM_BITS-3] of every flow block SHALL be replaced by status.
REQ-031 AM_STATUS_EN undefined: flow blocks emitted exactly as am_block; status input ignored.

Verification (NUM_FLOWS=2, AM_BITS=16, OUT_W=4, PAYLOAD_BEATS=3)
REQ-032 am_block=32'hABCD_1234, en=1, m_ready=1, no macro -> m_data 1,2,3,4,A,B,C,D with am_sof on beats 1 and A, then am_count=1.
REQ-033 Same with AM_STATUS_EN, status=3'b111 -> m_data F,2,3,4,E,B,C,D.
REQ-034 m_ready=0 for 3 cycles while m_data=3 -> m_data stays 3, m_valid stays 1, then 4 follows.
REQ-035 Payload s_data 5,6,7,8 with s_valid toggling -> exactly 5,6,7 pass with m_is_am=0; next beat is AM nibble 1; s_ready=0 throughout AM.
REQ-036 en dropped during payload beat 1 -> after 3rd payload transfer state IDLE, m_valid=0, am_count=1.
REQ-037 rst pulsed while m_data=B -> next cycle m_valid=0, am_count=0; en=1 -> restart at nibble 1.
